// File: rtl/ext_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module : ext_bus_responder_if
//  Brief  : Signal bundle for the ext_bus_responder. It carries the 8-bit
//           byte-serial external bus (outbound request bytes from the core,
//           inbound response bytes to the core) and the classic Wishbone
//           master port that the responder drives.
//  Ports  : ob_data/ob_pty      request byte + odd parity (core -> responder)
//           ib_data/ib_pty      response byte + odd parity (responder -> core)
//           wbm_*               Wishbone master signals (responder side)
//  Modports:
//           slave  - used by the responder (receives requests, drives WB)
//           master - used by the core side / bus model (sends requests,
//                    acts as the Wishbone slave)
//  Rev    : 1.0  initial release
// ============================================================================
interface ext_bus_responder_if;
   logic [7:0]  ob_data;
   logic        ob_pty;
   logic [7:0]  ib_data;
   logic        ib_pty;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   modport slave (
      input  ob_data, ob_pty, wbm_dat_i, wbm_ack_i, wbm_err_i,
      output ib_data, ib_pty, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   modport master (
      output ob_data, ob_pty, wbm_dat_i, wbm_ack_i, wbm_err_i,
      input  ib_data, ib_pty, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
endinterface
`default_nettype wire

// File: rtl/ext_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module : ext_bus_responder
//  Brief  : Target-side endpoint of the 8-bit external bus. Receives
//           byte-serial request frames (parity checked per byte), runs one
//           classic Wishbone cycle per valid frame and returns a byte-serial
//           response frame. Runs entirely in the bus clock domain.
//  Ports  : wb_clk_i       clock (same net as the core's oib_clk)
//           wb_rst_i       synchronous active-high reset
//           bus            ext_bus_responder_if.slave (ext bus + WB master)
//           pty_err_cnt    saturating count of bad-parity request bytes
//           proto_err_cnt  saturating count of protocol errors
//  Params : TIMEOUT        WB cycles without ack/err before abort (1..65535)
//  Rev    : 1.0  initial release
// ============================================================================
module ext_bus_responder #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   ext_bus_responder_if.slave      bus,
   output logic [7:0]              pty_err_cnt,
   output logic [7:0]              proto_err_cnt
);

   typedef enum logic [2:0] {
      RX_HDR  = 3'd0,
      RX_ADDR = 3'd1,
      RX_DATA = 3'd2,
      WB      = 3'd3,
      TX_HDR  = 3'd4,
      TX_DATA = 3'd5
   } state_t;

   localparam logic [7:0]  RSP_RD  = 8'h80;
   localparam logic [7:0]  RSP_WR  = 8'h81;
   localparam logic [7:0]  RSP_ERR = 8'hC0;
   // Counter value seen at the edge that must abort: cyc stays high for
   // exactly TIMEOUT cycles.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;        // write data, later reused for read data
   logic        frame_err_q, frame_err_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [7:0]  ib_data_q, ib_data_d;
   logic        ib_pty_q, ib_pty_d;
   logic [7:0]  pty_cnt_q, pty_cnt_d;
   logic [7:0]  proto_cnt_q, proto_cnt_d;

   logic        byte_good;
   logic        byte_idle;
   logic        pty_inc;
   logic        proto_inc;
   logic        frame_bad;
   logic [1:0]  cnt_inc;
   logic        in_wb;

   assign byte_good = ^{bus.ob_data, bus.ob_pty};
   assign byte_idle = (bus.ob_data == 8'h00);
   assign cnt_inc   = cnt_q + 2'd1;
   assign in_wb     = (state_q == WB);
   // Includes the byte being sampled now, so the 4th byte can still abort.
   assign frame_bad = frame_err_q | ~byte_good;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      frame_err_d = frame_err_q;
      to_cnt_d    = to_cnt_q;
      ib_data_d   = ib_data_q;
      pty_inc     = 1'b0;
      proto_inc   = 1'b0;

      case (state_q)
         RX_HDR: begin
            if (!byte_good) begin
               pty_inc = 1'b1;
            end else if (bus.ob_data[7]) begin
               if (bus.ob_data[5:4] != 2'b00) begin
                  proto_inc = 1'b1;
               end else begin
                  we_d        = bus.ob_data[6];
                  sel_d       = bus.ob_data[3:0];
                  cnt_d       = 2'd0;
                  frame_err_d = 1'b0;
                  state_d     = RX_ADDR;
               end
            end
         end

         RX_ADDR, RX_DATA: begin
            if (state_q == RX_ADDR) begin
               adr_d[{cnt_q, 3'b000} +: 8] = bus.ob_data;
            end else begin
               dat_d[{cnt_q, 3'b000} +: 8] = bus.ob_data;
            end
            if (!byte_good) begin
               pty_inc     = 1'b1;
               frame_err_d = 1'b1;
            end
            cnt_d = cnt_inc;
            if (cnt_q == 2'd3) begin
               if (frame_bad) begin
                  // Corrupted frame never reaches the bus.
                  ib_data_d = RSP_ERR;
                  state_d   = TX_HDR;
               end else if ((state_q == RX_ADDR) && we_q) begin
                  state_d = RX_DATA;
               end else begin
                  to_cnt_d = 16'd0;
                  state_d  = WB;
               end
            end
         end

         WB: begin
            to_cnt_d = to_cnt_q + 16'd1;
            // err has priority over a simultaneous ack.
            if (bus.wbm_err_i || (to_cnt_q == TO_LAST)) begin
               ib_data_d = RSP_ERR;
               state_d   = TX_HDR;
            end else if (bus.wbm_ack_i) begin
               if (we_q) begin
                  ib_data_d = RSP_WR;
               end else begin
                  dat_d     = bus.wbm_dat_i;
                  ib_data_d = RSP_RD;
               end
               state_d = TX_HDR;
            end
         end

         TX_HDR: begin
            if (ib_data_q == RSP_RD) begin
               ib_data_d = dat_q[7:0];
               cnt_d     = 2'd0;
               state_d   = TX_DATA;
            end else begin
               ib_data_d = 8'h00;
               state_d   = RX_HDR;
            end
         end

         TX_DATA: begin
            // cnt_q is the index of the byte currently on ib_data.
            if (cnt_q == 2'd3) begin
               ib_data_d = 8'h00;
               state_d   = RX_HDR;
            end else begin
               ib_data_d = dat_q[{cnt_inc, 3'b000} +: 8];
               cnt_d     = cnt_inc;
            end
         end

         default: begin
            ib_data_d = 8'h00;
            state_d   = RX_HDR;
         end
      endcase

      // Bytes arriving while busy are dropped but still accounted for.
      if ((state_q == WB) || (state_q == TX_HDR) || (state_q == TX_DATA)) begin
         if (!byte_good) begin
            pty_inc = 1'b1;
         end else if (!byte_idle) begin
            proto_inc = 1'b1;
         end
      end
   end

   assign ib_pty_d    = ~^ib_data_d;
   assign pty_cnt_d   = (pty_inc && (pty_cnt_q != 8'hFF))   ? pty_cnt_q + 8'd1   : pty_cnt_q;
   assign proto_cnt_d = (proto_inc && (proto_cnt_q != 8'hFF)) ? proto_cnt_q + 8'd1 : proto_cnt_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= RX_HDR;
         cnt_q       <= 2'd0;
         we_q        <= 1'b0;
         sel_q       <= 4'h0;
         adr_q       <= 32'h0;
         dat_q       <= 32'h0;
         frame_err_q <= 1'b0;
         to_cnt_q    <= 16'd0;
         ib_data_q   <= 8'h00;
         ib_pty_q    <= 1'b1;
         pty_cnt_q   <= 8'h00;
         proto_cnt_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         frame_err_q <= frame_err_d;
         to_cnt_q    <= to_cnt_d;
         ib_data_q   <= ib_data_d;
         ib_pty_q    <= ib_pty_d;
         pty_cnt_q   <= pty_cnt_d;
         proto_cnt_q <= proto_cnt_d;
      end
   end

   // Master outputs are forced low outside the bus cycle so the slave only
   // ever sees a fully formed request.
   assign bus.wbm_cyc_o = in_wb;
   assign bus.wbm_stb_o = in_wb;
   assign bus.wbm_we_o  = in_wb & we_q;
   assign bus.wbm_sel_o = in_wb ? sel_q : 4'h0;
   assign bus.wbm_adr_o = in_wb ? adr_q : 32'h0;
   assign bus.wbm_dat_o = (in_wb && we_q) ? dat_q : 32'h0;
   assign bus.ib_data   = ib_data_q;
   assign bus.ib_pty    = ib_pty_q;
   assign pty_err_cnt   = pty_cnt_q;
   assign proto_err_cnt = proto_cnt_q;

endmodule
`default_nettype wire
